// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback bus for regfile_scoreboard
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              regWrite;
    logic [1:0]        writeSpecReg;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic [1:0]        readSpecReg;
    logic [ADDR_W-1:0] rAddr1;
    logic [ADDR_W-1:0] rAddr2;
    logic [ADDR_W-1:0] rAddr3;
    logic [2:0]        rUse;
    logic [DATA_W-1:0] outData1;
    logic [DATA_W-1:0] outData2;
    logic [DATA_W-1:0] outData3;
    logic              issueValid;
    logic [1:0]        issueSpec;
    logic [ADDR_W-1:0] issueDst;
    logic              issueNoDst;
    logic              issueReady;
    logic              stall;

    modport master (
        output regWrite, writeSpecReg, wAddr, wData,
        output readSpecReg, rAddr1, rAddr2, rAddr3, rUse,
        output issueValid, issueSpec, issueDst, issueNoDst,
        input  outData1, outData2, outData3, issueReady, stall
    );

    modport slave (
        input  regWrite, writeSpecReg, wAddr, wData,
        input  readSpecReg, rAddr1, rAddr2, rAddr3, rUse,
        input  issueValid, issueSpec, issueDst, issueNoDst,
        output outData1, outData2, outData3, issueReady, stall
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - GPR/SP/IH/T register file with busy scoreboard and hazard stall
// Optional same-cycle write-to-read bypass: REGFILE_BYPASS_EN
module regfile_scoreboard #(
    parameter int                DATA_W   = 16,
    parameter int                GPR_CNT  = 8,
    parameter int                ADDR_W   = $clog2(GPR_CNT),
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(16'hBF00)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    regfile_scoreboard_if.slave  bus
);

    // Unified index space: GPRs first, then SP, IH, T.
    localparam int NREG  = GPR_CNT + 3;
    localparam int IDX_W = $clog2(NREG);
    localparam logic [IDX_W-1:0] SP_IDX = IDX_W'(GPR_CNT);
    localparam logic [IDX_W-1:0] IH_IDX = IDX_W'(GPR_CNT + 1);
    localparam logic [IDX_W-1:0] T_IDX  = IDX_W'(GPR_CNT + 2);

    function automatic logic [IDX_W-1:0] reg_idx(input logic [1:0] spec,
                                                 input logic [ADDR_W-1:0] addr);
        case (spec)
            2'b01:   return SP_IDX;
            2'b10:   return IH_IDX;
            2'b11:   return T_IDX;
            default: return IDX_W'(addr);
        endcase
    endfunction

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic [IDX_W-1:0]  src_idx [3];
    logic [DATA_W-1:0] rd_data [3];
    logic [2:0]        src_hit;
    logic [2:0]        src_busy;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  dst_idx;
    logic              waw_busy;
    logic              stall;
    logic              issue_ready;

    always_comb begin
        wr_idx     = reg_idx(bus.writeSpecReg, bus.wAddr);
        dst_idx    = reg_idx(bus.issueSpec, bus.issueDst);
        src_idx[0] = reg_idx(bus.readSpecReg, bus.rAddr1);
        src_idx[1] = reg_idx(2'b00, bus.rAddr2);
        src_idx[2] = reg_idx(2'b00, bus.rAddr3);
        src_hit    = '0;
        src_busy   = '0;
        for (int k = 0; k < 3; k++) begin
`ifdef REGFILE_BYPASS_EN
            src_hit[k] = bus.regWrite && (src_idx[k] == wr_idx);
`else
            src_hit[k] = 1'b0;
`endif
            rd_data[k]  = src_hit[k] ? bus.wData : regs_q[src_idx[k]];
            src_busy[k] = busy_q[src_idx[k]] & ~src_hit[k];
        end
        // The destination check has no writeback exemption: a pending producer blocks re-issue.
        waw_busy    = bus.issueValid & ~bus.issueNoDst & busy_q[dst_idx];
        stall       = (|(bus.rUse & src_busy)) | waw_busy;
        issue_ready = RST_N & bus.issueValid & ~stall;
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (bus.regWrite) begin
            regs_d[wr_idx] = bus.wData;
            busy_d[wr_idx] = 1'b0;
        end
        // Issue is applied after writeback so a same-cycle set wins for the new producer.
        if (issue_ready && !bus.issueNoDst) begin
            busy_d[dst_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == GPR_CNT) ? SP_RESET : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign bus.outData1   = rd_data[0];
    assign bus.outData2   = rd_data[1];
    assign bus.outData3   = rd_data[2];
    assign bus.stall      = stall;
    assign bus.issueReady = issue_ready;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
    localparam int DATA_W  = 16;
    localparam int GPR_CNT = 8;
    localparam int ADDR_W  = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_OUT1  = 0;
    localparam int S_OUT2  = 1;
    localparam int S_OUT3  = 2;
    localparam int S_READY = 3;
    localparam int S_STALL = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_scoreboard #(.DATA_W(DATA_W), .GPR_CNT(GPR_CNT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_OUT1:  return 32'(bus.outData1);
            S_OUT2:  return 32'(bus.outData2);
            S_OUT3:  return 32'(bus.outData3);
            S_READY: return 32'(bus.issueReady);
            default: return 32'(bus.stall);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_OUT1:  return "outData1";
            S_OUT2:  return "outData2";
            S_OUT3:  return "outData3";
            S_READY: return "issueReady";
            default: return "stall";
        endcase
    endfunction

    task automatic exp_push(input int sig, input logic [31:0] v);
        exp_t e;
        e.sig = sig;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string step);
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sig);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s/%s observed=%h expected=%h", step, sig_name(e.sig), obs, e.val);
            end
        end
    endtask

    task automatic idle();
        bus.regWrite     = 1'b0;
        bus.writeSpecReg = 2'b00;
        bus.wAddr        = '0;
        bus.wData        = '0;
        bus.readSpecReg  = 2'b00;
        bus.rAddr1       = '0;
        bus.rAddr2       = '0;
        bus.rAddr3       = '0;
        bus.rUse         = 3'b000;
        bus.issueValid   = 1'b0;
        bus.issueSpec    = 2'b00;
        bus.issueDst     = '0;
        bus.issueNoDst   = 1'b0;
    endtask

    initial begin
        idle();
        #1 RST_N = 1'b0;
        bus.issueValid = 1'b1;
        bus.issueDst   = 3'd3;
        bus.rUse       = 3'b111;
        #2;
        exp_push(S_READY, 0);
        exp_push(S_STALL, 0);
        check_now("reset_handshake");

        for (int i = 0; i < GPR_CNT; i++) begin
            bus.readSpecReg = 2'b00;
            bus.rAddr1      = ADDR_W'(i);
            bus.rAddr2      = ADDR_W'(i);
            bus.rAddr3      = ADDR_W'(GPR_CNT - 1 - i);
            #1;
            exp_push(S_OUT1, 0);
            exp_push(S_OUT2, 0);
            exp_push(S_OUT3, 0);
            check_now("reset_gpr");
        end
        bus.readSpecReg = 2'b01; #1; exp_push(S_OUT1, 32'hBF00); check_now("reset_sp");
        bus.readSpecReg = 2'b10; #1; exp_push(S_OUT1, 32'h0000); check_now("reset_ih");
        bus.readSpecReg = 2'b11; #1; exp_push(S_OUT1, 32'h0000); check_now("reset_t");

        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        idle();

        // Write then read
        @(negedge CLK); idle();
        bus.regWrite = 1'b1; bus.wAddr = 3'd3; bus.wData = 16'h1234;
        @(negedge CLK);
        bus.writeSpecReg = 2'b11; bus.wData = 16'h00FF;
        @(negedge CLK); idle();
        bus.readSpecReg = 2'b11; bus.rAddr2 = 3'd3; bus.rAddr3 = 3'd3;
        #1;
        exp_push(S_OUT1, 32'h00FF);
        exp_push(S_OUT2, 32'h1234);
        exp_push(S_OUT3, 32'h1234);
        check_now("write_read");

        // RAW on R5
        @(negedge CLK); idle();
        bus.issueValid = 1'b1; bus.issueDst = 3'd5;
        #1; exp_push(S_READY, 1); exp_push(S_STALL, 0); check_now("raw_issue");
        @(negedge CLK);
        bus.issueDst = 3'd6; bus.rAddr2 = 3'd5; bus.rUse = 3'b010;
        #1; exp_push(S_STALL, 1); exp_push(S_READY, 0); check_now("raw_stall");
        @(negedge CLK);
        bus.issueValid = 1'b0;
        bus.regWrite = 1'b1; bus.wAddr = 3'd5; bus.wData = 16'hBEEF;
        #1;
        exp_push(S_STALL, BYP ? 32'd0 : 32'd1);
        exp_push(S_OUT2, BYP ? 32'hBEEF : 32'h0000);
        check_now("raw_wb_cycle");
        @(negedge CLK);
        bus.regWrite = 1'b0;
        #1; exp_push(S_STALL, 0); exp_push(S_OUT2, 32'hBEEF); check_now("raw_after_wb");

        // WAW on R2, then simultaneous set/clear
        @(negedge CLK); idle();
        bus.issueValid = 1'b1; bus.issueDst = 3'd2;
        #1; exp_push(S_READY, 1); check_now("waw_first");
        @(negedge CLK);
        #1; exp_push(S_READY, 0); exp_push(S_STALL, 1); check_now("waw_second");
        @(negedge CLK);
        bus.issueValid = 1'b0;
        bus.regWrite = 1'b1; bus.wAddr = 3'd2; bus.wData = 16'h2222;
        #1; exp_push(S_STALL, 0); check_now("waw_wb");
        @(negedge CLK);
        bus.wData = 16'h3333; bus.issueValid = 1'b1; bus.issueDst = 3'd2;
        #1; exp_push(S_READY, 1); exp_push(S_STALL, 0); check_now("setclr_issue");
        @(negedge CLK); idle();
        bus.rAddr3 = 3'd2; bus.rUse = 3'b100;
        #1; exp_push(S_STALL, 1); exp_push(S_OUT3, 32'h3333); check_now("setclr_busy");
        @(negedge CLK);
        bus.regWrite = 1'b1; bus.wAddr = 3'd2; bus.wData = 16'h4444;
        #1;
        exp_push(S_STALL, BYP ? 32'd0 : 32'd1);
        exp_push(S_OUT3, BYP ? 32'h4444 : 32'h3333);
        check_now("setclr_wb_cycle");
        @(negedge CLK);
        bus.regWrite = 1'b0;
        #1; exp_push(S_STALL, 0); exp_push(S_OUT3, 32'h4444); check_now("setclr_after");

        // SP scoreboard
        @(negedge CLK); idle();
        bus.issueValid = 1'b1; bus.issueSpec = 2'b01;
        #1; exp_push(S_READY, 1); check_now("sp_issue");
        @(negedge CLK); idle();
        bus.readSpecReg = 2'b01; bus.rUse = 3'b001;
        #1; exp_push(S_STALL, 1); exp_push(S_OUT1, 32'hBF00); check_now("sp_stall");
        @(negedge CLK);
        #1; exp_push(S_STALL, 1); check_now("sp_stall_hold");
        @(negedge CLK);
        bus.regWrite = 1'b1; bus.writeSpecReg = 2'b01; bus.wData = 16'h7FFE;
        #1;
        exp_push(S_STALL, BYP ? 32'd0 : 32'd1);
        exp_push(S_OUT1, BYP ? 32'h7FFE : 32'hBF00);
        check_now("sp_wb_cycle");
        @(negedge CLK);
        bus.regWrite = 1'b0;
        #1; exp_push(S_STALL, 0); exp_push(S_OUT1, 32'h7FFE); check_now("sp_after");

        // Async reset mid-operation
        @(negedge CLK); idle();
        bus.issueValid = 1'b1; bus.issueDst = 3'd1;
        #1; exp_push(S_READY, 1); check_now("ar_issue");
        @(negedge CLK);
        bus.regWrite = 1'b1; bus.wAddr = 3'd1; bus.wData = 16'hAAAA;
        bus.rAddr1 = 3'd1; bus.rAddr2 = 3'd5; bus.rUse = 3'b001;
        #1; exp_push(S_STALL, 1); exp_push(S_READY, 0); check_now("ar_pending");
        #1 RST_N = 1'b0;
        #1;
        exp_push(S_STALL, 0);
        exp_push(S_READY, 0);
        exp_push(S_OUT2, 32'h0000);
        check_now("ar_immediate");
        @(posedge CLK);
        @(negedge CLK);
        bus.regWrite = 1'b0; bus.issueValid = 1'b0;
        #1; exp_push(S_OUT1, 32'h0000); exp_push(S_STALL, 0); check_now("ar_discard");
        @(negedge CLK);
        RST_N = 1'b1;
        bus.issueValid = 1'b1; bus.issueDst = 3'd1;
        #1; exp_push(S_STALL, 0); exp_push(S_READY, 1); check_now("ar_release");

        @(negedge CLK); idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 8×16 register file with SP/IH/T special registers.
- Generalises data width and general-register count, adds a reset, and adds a third read port.
- Adds a per-register busy scoreboard with an issue/writeback handshake, so the pipeline's decode stage gets a hazard stall directly from the register file.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- DATA_W, 16, width of every register.
- GPR_CNT, 8, number of general registers; power of two, ≥2.
- ADDR_W, $clog2(GPR_CNT), general-register address width (derived; do not override).
- SP_RESET, 16'hBF00 (sized to DATA_W), reset value of SP; all other registers reset to 0.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous active-low reset.
- regWrite  in  1  writeback strobe.
- writeSpecReg  in  2  write target: 00 = GPR[wAddr], 01 = SP, 10 = IH, 11 = T.
- wAddr  in  ADDR_W  GPR write index.
- wData  in  DATA_W  write data.
- readSpecReg  in  2  port 1 source: 00 = GPR[rAddr1], 01 = SP, 10 = IH, 11 = T.
- rAddr1  in  ADDR_W  port 1 GPR index.
- rAddr2  in  ADDR_W  port 2 GPR index.
- rAddr3  in  ADDR_W  port 3 GPR index (GPR only).
- rUse  in  3  bit i set = port i+1 is consumed this cycle; gates stall only.
- outData1  out  DATA_W  port 1 data.
- outData2  out  DATA_W  port 2 data.
- outData3  out  DATA_W  port 3 data.
- issueValid  in  1  decode requests issue of an instruction.
- issueSpec  in  2  destination class, same encoding as writeSpecReg.
- issueDst  in  ADDR_W  destination GPR index when issueSpec = 00.
- issueNoDst  in  1  instruction writes no register.
- issueReady  out  1  issue accepted this cycle.
- stall  out  1  a used source or the destination is busy.

Behaviour:
- Storage: GPR_CNT general registers plus SP, IH, T; all DATA_W wide.
- Reset (RST_N low, asynchronous): all GPRs = 0, IH = 0, T = 0, SP = SP_RESET, all busy bits = 0.
- Reset values at outputs: read outputs combinationally show the reset register contents; issueReady = 0 while in reset; stall = 0.
- Reset asserted mid-operation discards all pending writes and busy bits immediately.
- Write: on posedge with regWrite = 1, the selected register takes wData. No write-enable-free path.
- Read: combinational, zero latency; writes become visible after the posedge (plus the same-cycle bypass below when enabled).
- Scoreboard state: one busy bit per destination, GPR_CNT + 3 bits total.
- Source busy: a port's source is busy if its busy bit is set AND it is not being written by regWrite this cycle (the latter exemption applies only with the bypass feature).
- stall = 1 if any port with rUse set has a busy source, OR issueValid with !issueNoDst targets a busy destination (WAW).
- issueReady = issueValid & !stall.
- Issue effect: when issueReady = 1 and !issueNoDst, set the destination's busy bit at posedge.
- Writeback effect: regWrite clears the written register's busy bit at posedge.
- Simultaneous issue and writeback to the same register: set wins; the bit stays 1 for the new producer.
- Stalled issue: no state change.
- Writeback to a non-busy register: allowed; the busy bit stays 0.
- Index wrap: indices are exactly ADDR_W bits, so no out-of-range access is possible.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose source matches the register being written this cycle returns wData combinationally. That source is not counted as busy for stall.
- Undefined: reads return the stored value only. A source being written this cycle still counts as busy, giving one extra stall cycle.
- Either way, storage updates at posedge.

Test Plan:
- Reset values: RST_N low, then release. Read GPR0–7 and SP/IH/T → all 0 except SP = 16'hBF00. issueReady = 0 during reset.
- Write then read: write GPR3 = 16'h1234 and T = 16'h00FF in two cycles, then read port1 T, port2 R3, port3 R3 → 16'h00FF, 16'h1234, 16'h1234.
- RAW stall: issue to R5 (accepted). Next cycle rAddr2 = 5 with rUse[1] = 1 → stall = 1 and issueReady = 0. After a regWrite to R5 with 16'hBEEF, stall drops.
  - With REGFILE_BYPASS_EN: outData2 = 16'hBEEF in the write cycle and stall = 0 that cycle.
  - Without REGFILE_BYPASS_EN: stall = 1 in the write cycle; outData2 = 16'hBEEF one cycle later.
- WAW and simultaneous set/clear:
  - Issue to R2 twice → the second issue is stalled.
  - Writeback to R2 plus a same-cycle issue to R2 → R2 is still busy afterwards, and the next read of R2 with rUse set stalls.
- Special-register scoreboard: issue with issueSpec = 01 → SP is busy. A read with readSpecReg = 01 and rUse[0] = 1 stalls until a writeback with writeSpecReg = 01 of 16'h7FFE, after which port 1 reads 16'h7FFE.
- Async reset mid-operation: R1 busy and a write pending, then pull RST_N low between clock edges → busy cleared immediately, R1 = 0, stall = 0, with no clock edge required.
